// File: rtl/sys_arr_pkg.sv
// Shared types and constants for the systolic-array writeback path.
package sys_arr_pkg;

  localparam int unsigned VREG_W   = 512;
  localparam int unsigned WB_DST_W = 8;
  localparam int unsigned WB_DEPTH = 4;

  typedef logic [VREG_W-1:0] vreg_t;

  typedef struct packed {
    vreg_t               psum;
    logic [WB_DST_W-1:0] dst;
  } wb_entry_t;

  // Saturating 32-bit increment used by the optional activity counters.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/gsau_wb_buffer_fifo.sv
// wb_fifo: generic synchronous first-word-fall-through FIFO.
// Pointers wrap naturally; a separate occupancy count disambiguates
// full from empty. No full-bypass: a push while full is dropped even
// if a pop happens in the same cycle.
module wb_fifo
  import sys_arr_pkg::*;
#(
  parameter int unsigned DEPTH   = WB_DEPTH,
  parameter type         entry_t = wb_entry_t,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  entry_t           wr_data,
  input  logic             pop,
  output entry_t           rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head entry is presented while occupied; zero when empty so the
  // downstream data/address read as 0 out of reset.
  assign rd_data = empty ? '0 : mem[rp];

  // Storage array: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wp] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wp <= wp + PTR_W'(1);
      end
      if (do_pop) begin
        rp <= rp + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gsau_wb_buffer.sv
// gsau_wb_buffer: writeback buffer between the GSAU and the Veggie File
// write port. Queues {psum, dst} entries in order, drains them to the
// write port, and pulses completion to the scoreboard one cycle after
// each committed write.
// Optional build macro: WB_STALL_CNT_EN adds saturating stall_cycles and
// full_cycles activity counters.
module gsau_wb_buffer
  import sys_arr_pkg::*;
#(
  parameter int unsigned DEPTH  = WB_DEPTH,
  parameter int unsigned DST_W  = WB_DST_W,
  parameter int unsigned DATA_W = VREG_W
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [DATA_W-1:0]        wb_psum,
  input  logic [DST_W-1:0]         wb_wbdst,
  input  logic                     wb_valid,
  output logic                     wb_output_ready,
  output logic [DATA_W-1:0]        vwr_data,
  output logic [DST_W-1:0]         vwr_dst,
  output logic                     vwr_valid,
  input  logic                     vwr_ready,
  output logic                     sb_wb_done,
  output logic [DST_W-1:0]         sb_wb_dst,
`ifdef WB_STALL_CNT_EN
  output logic [31:0]              stall_cycles,
  output logic [31:0]              full_cycles,
`endif
  output logic [$clog2(DEPTH):0]   wb_count
);

  // Same layout as wb_entry_t, sized from this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] psum;
    logic [DST_W-1:0]  dst;
  } entry_t;

  entry_t wr_entry;
  entry_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;

  assign wr_entry = '{psum: wb_psum, dst: wb_wbdst};

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (nRST),
    .push    (wb_valid),
    .wr_data (wr_entry),
    .pop     (vwr_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (wb_count)
  );

  // Ready depends only on registered occupancy, never on wb_valid.
  assign wb_output_ready = !fifo_full;
  assign vwr_valid       = !fifo_empty;
  assign vwr_data        = head.psum;
  assign vwr_dst         = head.dst;
  assign pop             = vwr_valid && vwr_ready;

  // Registered completion: pulse with the popped dst the cycle after a pop.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      sb_wb_done <= 1'b0;
      sb_wb_dst  <= '0;
    end else begin
      sb_wb_done <= pop;
      if (pop) begin
        sb_wb_dst <= head.dst;
      end
    end
  end

`ifdef WB_STALL_CNT_EN
  // Activity counters: write-port stall cycles and buffer-full cycles.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles <= '0;
      full_cycles  <= '0;
    end else begin
      if (vwr_valid && !vwr_ready) begin
        stall_cycles <= sat_inc32(stall_cycles);
      end
      if (fifo_full) begin
        full_cycles <= sat_inc32(full_cycles);
      end
    end
  end
`endif

endmodule

// File: doc/gsau_wb_buffer.md
Name: gsau_wb_buffer

Overview:
- Writeback buffer directly downstream of the GSAU.
- Accepts 512-bit partial-sum vectors and their destination register index through a valid/ready handshake, and queues them in an in-order FIFO.
- Drains entries to the Veggie File write port, then signals write completion to the scoreboard so the destination register can be released.
- Absorbs Veggie File write-port stalls so the systolic array output does not back up.

Parameters:
- DEPTH, 4, number of buffered entries; must be a power of 2 and at least 2.
- DST_W, 8, width of the destination register index.
- DATA_W, 512, width of the psum vector; equals the vreg_t width.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset; synchronous, active-low.
- wb_psum  input  DATA_W  partial-sum vector from the GSAU.
- wb_wbdst  input  DST_W  destination vreg index from the GSAU.
- wb_valid  input  1  GSAU offers an entry.
- wb_output_ready  output  1  buffer can accept an entry (not full).
- vwr_data  output  DATA_W  write data to the Veggie File.
- vwr_dst  output  DST_W  write address to the Veggie File.
- vwr_valid  output  1  write request.
- vwr_ready  input  1  Veggie File accepts the write this cycle.
- sb_wb_done  output  1  one-cycle pulse: a write committed.
- sb_wb_dst  output  DST_W  register index of the committed write.
- wb_count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (nRST low at a CLK edge):
  - wp, rp, count go to 0.
  - wb_output_ready goes to 1.
  - vwr_valid, sb_wb_done go to 0.
  - vwr_data, vwr_dst, sb_wb_dst go to 0.
  - Reset mid-operation discards all entries; no done pulse is issued for them.
- Push: occurs when wb_valid && wb_output_ready at a CLK edge.
  - The entry {psum, dst} is written at wp, and wp increments modulo DEPTH.
- wb_output_ready = (count != DEPTH). It is combinational from registered count only and never depends on wb_valid.
  - When full there is no push, even if a pop happens in the same cycle (no full-bypass).
- Output side is first-word-fall-through:
  - vwr_valid = (count != 0).
  - vwr_data and vwr_dst come from the entry at rp.
  - An entry pushed at edge N is visible on vwr_* after edge N (cycle N+1). Minimum push-to-write latency is 1 cycle.
- Pop: occurs when vwr_valid && vwr_ready at a CLK edge; rp increments modulo DEPTH.
  - While vwr_valid=1 && vwr_ready=0, vwr_data and vwr_dst hold stable.
- Simultaneous push and pop (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
  - With count==0, only a push is possible.
- Completion: sb_wb_done and sb_wb_dst are registered.
  - On a pop at edge N, sb_wb_done=1 and sb_wb_dst=the popped dst during cycle N+1.
  - sb_wb_done is otherwise 0.
  - Back-to-back pops produce back-to-back pulses.
- Ordering is strict FIFO; no dst coalescing or reordering.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately, to disambiguate full from empty.
- wb_count = count; it is registered.
- Empty: no vwr_valid. Full: no wb_output_ready. Neither condition is an error.

Optional Feature:
- Macro: WB_STALL_CNT_EN.
- When defined, adds two outputs:
  - stall_cycles, 32 bits: increments every cycle vwr_valid && !vwr_ready, and saturates at 32'hFFFFFFFF.
  - full_cycles, 32 bits: increments every cycle count==DEPTH, and saturates the same way.
  - Both reset to 0 on nRST.
- When undefined, these ports and registers are absent and the remaining behaviour is identical.

Decomposition:
- In sys_arr_pkg:
  - typedef wb_entry_t, a packed struct {vreg_t psum; logic [7:0] dst;}.
  - localparam WB_DEPTH = 4.
- One sub-module, wb_fifo: a generic synchronous FWFT FIFO of wb_entry_t with push/pop/full/empty/count.
- gsau_wb_buffer itself adds the handshake mapping, the registered completion pulse, and the optional counters.

Test Plan:
- Single push, idle sink:
  - Stimulus: psum=512'hA5…A5, dst=8'h12, vwr_ready=1.
  - Response: vwr_valid=1 with matching data/dst in cycle N+1; sb_wb_done=1, sb_wb_dst=8'h12 in cycle N+2; wb_count returns to 0.
- Fill to full with vwr_ready=0:
  - Stimulus: push dst 1,2,3,4.
  - Response: wb_output_ready=0 after the 4th push and wb_count=4. A 5th wb_valid is not accepted.
  - Then raise vwr_ready: writes are issued in order 1,2,3,4 and done pulses follow 1 cycle behind each.
- Stall hold:
  - Stimulus: entry dst=8'h07 present, vwr_ready=0 for 5 cycles.
  - Response: vwr_data/vwr_dst are stable for all 5 cycles and there is no done pulse. With WB_STALL_CNT_EN, stall_cycles=5.
- Simultaneous push and pop:
  - Stimulus: count=2, wb_valid=1 and vwr_ready=1 held for 10 cycles.
  - Response: count stays 2 throughout; pointers wrap past DEPTH; output order matches input order.
- Reset mid-operation:
  - Stimulus: count=3, vwr_ready=0, nRST low for one edge.
  - Response: after the edge, vwr_valid=0, wb_count=0, wb_output_ready=1, and no sb_wb_done.
  - A new push afterwards is written correctly.
